// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter sharing one UART transmitter core among NREQ byte
//   producers. The owner keeps the grant for a whole packet (up to
//   MAX_BURST bytes); each byte is sequenced through a start/busy handshake
//   with the transmitter.
//
// Handshakes:
//   Requester side: i_req[i] is held high with i_req_data/i_req_last stable
//   until o_ack[i] pulses for one cycle; the byte is consumed on that pulse.
//   Transmitter side: o_tx_start pulses one cycle with o_tx_data valid (and
//   held afterwards); the core raises i_tx_busy while shifting. If busy never
//   rises within BUSY_TIMEOUT cycles the byte is treated as sent.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_req        per-requester byte valid
//   i_req_data   byte of requester i at [8i+7:8i]
//   i_req_last   byte of requester i ends its packet
//   o_ack        one-cycle pulse, byte of requester i taken
//   o_grant      one-hot transmitter owner, zero when idle
//   o_tx_start   one-cycle start pulse to the transmitter
//   o_tx_data    byte for the transmitter
//   i_tx_busy    transmitter is shifting a frame
//   o_active     FSM is not in IDLE
//   o_dbg_state  current FSM state encoding
module uart_tx_arbiter #(
  parameter int NREQ         = 4,
  parameter int MAX_BURST    = 16,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NREQ-1:0]     i_req,
  input  logic [8*NREQ-1:0]   i_req_data,
  input  logic [NREQ-1:0]     i_req_last,
  output logic [NREQ-1:0]     o_ack,
  output logic [NREQ-1:0]     o_grant,
  output logic                o_tx_start,
  output logic [7:0]          o_tx_data,
  input  logic                i_tx_busy,
  output logic                o_active,
  output logic [1:0]          o_dbg_state
);

  localparam int IW = $clog2(NREQ);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_LOAD      = 2'd1;
  localparam logic [1:0] S_WAIT_BUSY = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  logic [1:0]      r_state;
  logic [IW-1:0]   r_last;
  logic [IW-1:0]   r_gidx;
  logic [NREQ-1:0] r_grant;
  logic [NREQ-1:0] r_ack;
  logic            r_tx_start;
  logic [7:0]      r_tx_data;
  logic            r_active;
  logic [7:0]      r_burst;
  logic [3:0]      r_tout;
  logic            r_pkt_last;

  logic            w_any;
  logic [IW-1:0]   w_sel;
  int              w_scan;
  logic            w_g_req;
  logic [7:0]      w_g_data;
  logic            w_g_last;
  logic            w_eob_now;
  logic            w_eob_release;
  logic            w_release;
  logic            w_reload;

  // Round-robin pick: scanning offsets from NREQ down to 1 lets the smallest
  // offset after r_last overwrite any later candidate, so it wins.
  always_comb begin
    w_any  = 1'b0;
    w_sel  = '0;
    w_scan = 0;
    for (int off = NREQ; off >= 1; off--) begin
      w_scan = (int'(r_last) + off) % NREQ;
      if (i_req[IW'(w_scan)]) begin
        w_any = 1'b1;
        w_sel = IW'(w_scan);
      end
    end
  end

  assign w_g_req  = i_req[r_gidx];
  assign w_g_data = i_req_data[{r_gidx, 3'b000} +: 8];
  assign w_g_last = i_req_last[r_gidx];

  // A byte is finished when the core drops busy, or when busy never showed
  // up within the timeout window.
  assign w_eob_now = (r_state == S_WAIT_DONE && !i_tx_busy) ||
                     (r_state == S_WAIT_BUSY && !i_tx_busy &&
                      r_tout == 4'(BUSY_TIMEOUT - 1));
  assign w_eob_release = r_pkt_last || (r_burst == 8'(MAX_BURST));

  // Release either ends the packet/burst or handles a requester that
  // withdrew before its byte was loaded.
  assign w_release = (r_state == S_LOAD && !w_g_req) ||
                     (w_eob_now && w_eob_release);
  assign w_reload  = w_eob_now && !w_eob_release;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_last     <= IW'(NREQ - 1);
      r_gidx     <= '0;
      r_grant    <= '0;
      r_ack      <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
      r_active   <= 1'b0;
      r_burst    <= 8'd0;
      r_tout     <= 4'd0;
      r_pkt_last <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      r_ack      <= '0;
      if (w_release) begin
        r_grant  <= '0;
        r_last   <= r_gidx;
        r_state  <= S_IDLE;
        r_active <= 1'b0;
      end else if (w_reload) begin
        r_state <= S_LOAD;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_any) begin
              r_grant  <= {{(NREQ-1){1'b0}}, 1'b1} << w_sel;
              r_gidx   <= w_sel;
              r_burst  <= 8'd0;
              r_active <= 1'b1;
              r_state  <= S_LOAD;
            end
          end
          S_LOAD: begin
            // w_g_req is high here; the low case is handled by w_release.
            r_tx_data  <= w_g_data;
            r_tx_start <= 1'b1;
            r_ack      <= {{(NREQ-1){1'b0}}, 1'b1} << r_gidx;
            r_pkt_last <= w_g_last;
            r_burst    <= r_burst + 8'd1;
            r_tout     <= 4'd0;
            r_state    <= S_WAIT_BUSY;
          end
          S_WAIT_BUSY: begin
            if (i_tx_busy) begin
              r_state <= S_WAIT_DONE;
            end else begin
              r_tout <= r_tout + 4'd1;
            end
          end
          S_WAIT_DONE: begin
            // Stays here while busy; the falling edge is caught by w_eob_now.
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_ack       = r_ack;
  assign o_grant     = r_grant;
  assign o_tx_start  = r_tx_start;
  assign o_tx_data   = r_tx_data;
  assign o_active    = r_active;
  assign o_dbg_state = r_state;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter core among `NREQ` byte-stream requesters. It sits between several producers (echo path, status reporter, debug dump) and the single `tx` serializer in `MAIN`. The grant is held for a whole packet, up to `MAX_BURST` bytes. It sequences each byte through a start/busy handshake with the transmitter.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `MAX_BURST`, default 16: max bytes per grant before forced release, 1..255.
- `BUSY_TIMEOUT`, default 4: cycles to wait for `tx_busy` to rise after `tx_start`, 1..15.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  NREQ  per-requester byte valid; held until `ack`.
- `req_data`  in  8*NREQ  byte for requester i at bits [8i+7:8i].
- `req_last`  in  NREQ  byte on requester i is the last of its packet.
- `ack`  out  NREQ  one-cycle pulse: byte of requester i taken.
- `grant`  out  NREQ  one-hot owner of transmitter; all zero when idle.
- `tx_start`  out  1  one-cycle pulse to the transmitter core.
- `tx_data`  out  8  byte for the transmitter; valid with `tx_start`, then held.
- `tx_busy`  in  1  transmitter shifting (start, data, stop bits).
- `active`  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, LOAD, WAIT_BUSY, WAIT_DONE. All outputs are registered.
- Reset values: `grant`=0, `ack`=0, `tx_start`=0, `tx_data`=8'h00, `active`=0. Round-robin pointer `last`=NREQ-1, so requester 0 wins first. Burst counter=0, state=IDLE.
- IDLE, any `req` high:
  - Select the first set bit scanning `last+1, last+2, …` modulo NREQ.
  - Load `grant` one-hot, clear the burst counter, go to LOAD.
- LOAD, `req[g]` high:
  - `tx_data<=req_data[g]`, pulse `tx_start` and `ack[g]`.
  - Latch `req_last[g]`, increment the burst counter, clear the timeout counter, go to WAIT_BUSY.
- LOAD, `req[g]` low (requester withdrew): release, see below.
- WAIT_BUSY:
  - Go to WAIT_DONE when `tx_busy`=1.
  - Otherwise increment the timeout counter. At `BUSY_TIMEOUT` treat the byte as sent and go to the end-of-byte check.
- WAIT_DONE: stay while `tx_busy`=1. On `tx_busy`=0, do the end-of-byte check.
- End-of-byte check:
  - If latched last=1 or burst counter==MAX_BURST: release.
  - Else go to LOAD, keeping the grant.
- Release: `grant<=0`, `last<=index(g)`, state to IDLE.
- A requester that is not granted never sees `ack`. `req_data` of non-granted requesters is ignored.
- Simultaneous requests are resolved only in IDLE. New `req` assertions during a grant wait for release.
- `rst` mid-byte: outputs clear immediately. The transmitter core is reset by the same `rst`; no partial-byte recovery.

## Timing
- `req` rises before edge k while in IDLE: `grant`/`active` high after edge k.
- `tx_start`, `ack[g]`, `tx_data` valid after edge k+1. `tx_start`/`ack` drop after edge k+2.
- Minimum gap between consecutive `tx_start` pulses in one packet: byte time + 2 cycles. With a 10-clk/bit core (100 clk per frame) this is about 102 clk.
- After release, IDLE can re-grant at the next edge, so there is 1 idle cycle with `grant`=0 between owners.
- `tx_busy` high at the same edge that `tx_start` is seen is accepted (WAIT_BUSY exits next edge).
- Timeout path: release or reload exactly `BUSY_TIMEOUT` cycles after entering WAIT_BUSY.

## Test plan
- **Reset:** assert `rst` for 5 clk mid-stream. All outputs 0 asynchronously, before the next edge. After release, requester 0 wins first.
- **Single byte:**
  - Stimulus: `req[2]`=1, data 8'hA5, last=1. Bench transmitter model: `tx_busy` 1 clk after start, for 100 clk.
  - Required: `grant`=4'b0100 at edge k; one `tx_start` with `tx_data`=8'hA5 and one `ack[2]` at k+1; `grant`=0 after busy falls.
- **Contention:** `req`=4'b1011 constant, each a 1-byte packet. Grant order 0,1,3,0,1,3. Exactly one `tx_start` per grant.
- **Packet hold:**
  - Requester 1 sends 3 bytes (8'h10, 8'h11, 8'h12 with last on the third) while `req[0]` is held.
  - Required: all 3 bytes go out back-to-back before `grant` moves to 0.
- **Burst cap:** MAX_BURST=2, requester 3 streams 5 bytes, `req[1]` pending. Sequence on the transmitter: 3,3,1,3,3,…; `grant` released after 2 bytes each time.
- **Timeout:** `tx_busy` tied 0, 1-byte packet. `grant` released exactly `BUSY_TIMEOUT`=4 cycles after `tx_start`; no hang.
